// File: rtl/multi_port_queue_if.sv
// Bundle between decode (enqueue lanes) and dispatch (dequeue lanes) for multi_port_queue.
// Latency: wires only; the queue owns all timing.
// Backpressure: o_can_enq gates a whole enqueue bundle; o_deq_vld qualifies dequeue lanes.
interface multi_port_queue_if #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int INPORTS  = 4,
  parameter int OUTPORTS = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                        i_flush;
  logic [INPORTS-1:0]          i_enq_req;
  logic [INPORTS*WIDTH-1:0]    i_enq_data;
  logic                        o_can_enq;
  logic [OUTPORTS-1:0]         o_deq_vld;
  logic [OUTPORTS*WIDTH-1:0]   o_deq_data;
  logic [OUTPORTS-1:0]         i_deq_req;
  logic [CW-1:0]               o_count;

  // Producer/consumer side (decode + dispatch).
  modport master (
    output i_flush, i_enq_req, i_enq_data, i_deq_req,
    input  o_can_enq, o_deq_vld, o_deq_data, o_count
  );

  // Queue side.
  modport slave (
    input  i_flush, i_enq_req, i_enq_data, i_deq_req,
    output o_can_enq, o_deq_vld, o_deq_data, o_count
  );
endinterface

// File: rtl/multi_port_queue.sv
// In-order circular queue: up to INPORTS pushes and OUTPORTS pops per cycle (optional checks: MULTI_PORT_QUEUE_CHECK_EN).
// Latency: an entry written at edge N is visible on the dequeue lanes after that edge; reads are combinational.
// Backpressure: bundle dropped unless INPORTS slots free (registered count only); pops clipped to occupancy.
module multi_port_queue #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int INPORTS  = 4,
  parameter int OUTPORTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  multi_port_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [WIDTH-1:0] storage_d [DEPTH];
  logic             can_enq;
  logic [CW-1:0]    nenq;
  logic [CW-1:0]    ndeq;

  // Length of the run of ones starting at lane 0; anything above the first zero is ignored.
  function automatic int continuous_one_enq(input logic [INPORTS-1:0] m);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < INPORTS; i++) begin
      run = run & m[i];
      if (run) n++;
    end
    return n;
  endfunction

  function automatic int continuous_one_deq(input logic [OUTPORTS-1:0] m);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < OUTPORTS; i++) begin
      run = run & m[i];
      if (run) n++;
    end
    return n;
  endfunction

  // Effective lane counts: enqueue needs room for a full bundle, dequeue clipped to occupancy.
  always_comb begin
    int n;
    can_enq = (CW'(DEPTH) - count_q) >= CW'(INPORTS);
    nenq    = can_enq ? CW'(continuous_one_enq(q.i_enq_req)) : '0;
    n       = continuous_one_deq(q.i_deq_req);
    if (n > int'(count_q)) n = int'(count_q);
    ndeq    = CW'(n);
  end

  // Pointer and occupancy update; flush overrides any same-cycle push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(ndeq);
      tail_d  = tail_q + PW'(nenq);
      count_d = count_q + nenq - ndeq;
    end
  end

  // Write accepted lanes at tail+k, wrapping naturally through the PW-bit index.
  always_comb begin
    storage_d = storage_q;
    if (!q.i_flush) begin
      for (int k = 0; k < INPORTS; k++) begin
        if (CW'(k) < nenq) storage_d[tail_q + PW'(k)] = q.i_enq_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Dequeue lanes present head+k straight from storage; no enqueue bypass.
  always_comb begin
    q.o_deq_vld  = '0;
    q.o_deq_data = '0;
    for (int k = 0; k < OUTPORTS; k++) begin
      q.o_deq_vld[k]                  = count_q > CW'(k);
      q.o_deq_data[k*WIDTH +: WIDTH]  = storage_q[head_q + PW'(k)];
    end
  end

  assign q.o_can_enq = can_enq;
  assign q.o_count   = count_q;

  // Control state clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload array is left unreset; validity comes from count alone.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

`ifdef MULTI_PORT_QUEUE_CHECK_EN
  int unsigned cycle_cnt;

  // Cycle stamp for check messages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= 0;
    else     cycle_cnt <= cycle_cnt + 1;
  end

  // Protocol and consistency checks on the lane masks and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((q.i_enq_req & (q.i_enq_req + INPORTS'(1))) == '0)
        else $error("multi_port_queue: non-prefix i_enq_req %b at cycle %0d", q.i_enq_req, cycle_cnt);
      assert (!(q.i_enq_req != '0 && !can_enq))
        else $error("multi_port_queue: enqueue while full at cycle %0d", cycle_cnt);
      assert ((q.i_deq_req & (q.i_deq_req + OUTPORTS'(1))) == '0)
        else $error("multi_port_queue: non-prefix i_deq_req %b at cycle %0d", q.i_deq_req, cycle_cnt);
      assert ((q.i_deq_req & ~q.o_deq_vld) == '0)
        else $error("multi_port_queue: dequeue of invalid lane %b at cycle %0d", q.i_deq_req, cycle_cnt);
      assert (count_q <= CW'(DEPTH))
        else $error("multi_port_queue: count %0d exceeds depth at cycle %0d", count_q, cycle_cnt);
    end
  end
`endif
endmodule
